// File: rtl/decode_lookup.sv
`default_nettype none
// ============================================================================
// Module   : decode_lookup
// Purpose  : Reverse lookup array_code -> in-scope metadata handle over a small
//            write-loaded table, scanning one cell per clock.
// Revision : 1.0
// ============================================================================
module decode_lookup #(
    parameter int  NUM_CELLS = 8,
    parameter int  WIDTH     = 8,
    parameter int  MAX_META  = 7,
    localparam int c_slot_w  = $clog2(NUM_CELLS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [c_slot_w-1:0] wr_slot,
    input  logic                wr_arrDef,
    input  logic [WIDTH-1:0]    wr_handle,
    input  logic [WIDTH-1:0]    wr_array_code,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [WIDTH-1:0]    req_code,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic                resultBool,
    output logic [WIDTH-1:0]    resultMetadata,
    output logic [c_slot_w-1:0] resultSlot,
    output logic                isMetadata
);

    localparam logic [WIDTH-1:0]    c_max_meta = WIDTH'(MAX_META);
    localparam logic [c_slot_w-1:0] c_last_idx = c_slot_w'(NUM_CELLS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_RESP = 2'd2
    } state_t;

    logic [NUM_CELLS-1:0] r_arr_def;
    logic [WIDTH-1:0]     r_handle [NUM_CELLS];
    logic [WIDTH-1:0]     r_code   [NUM_CELLS];

    state_t               r_state;
    logic [c_slot_w-1:0]  r_idx;
    logic [WIDTH-1:0]     r_req_code;
    logic                 r_req_ready;
    logic                 r_resp_valid;
    logic                 r_result_bool;
    logic [WIDTH-1:0]     r_result_meta;
    logic [c_slot_w-1:0]  r_result_slot;

    logic                 w_match;
    logic                 w_last;

    // Only the valid bits need clearing; stale handle/code are masked by them.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_arr_def <= '0;
        end else if (wr_en) begin
            r_arr_def[wr_slot] <= wr_arrDef;
            r_handle[wr_slot]  <= wr_handle;
            r_code[wr_slot]    <= wr_array_code;
        end
    end

    // Reads the pre-write table contents, so a same-cycle write to r_idx is not seen.
    assign w_match = r_arr_def[r_idx]
                   && (r_code[r_idx] == r_req_code)
                   && (r_handle[r_idx] <= c_max_meta);
    assign w_last  = (r_idx == c_last_idx);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_req_code    <= '0;
            r_req_ready   <= 1'b1;
            r_resp_valid  <= 1'b0;
            r_result_bool <= 1'b0;
            r_result_meta <= '0;
            r_result_slot <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_req_code  <= req_code;
                        r_idx       <= '0;
                        r_req_ready <= 1'b0;
                        r_state     <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (w_match) begin
                        r_result_bool <= 1'b1;
                        r_result_meta <= r_handle[r_idx];
                        r_result_slot <= r_idx;
                        r_resp_valid  <= 1'b1;
                        r_state       <= S_RESP;
                    end else if (w_last) begin
                        r_result_bool <= 1'b0;
                        r_result_meta <= '0;
                        r_result_slot <= '0;
                        r_resp_valid  <= 1'b1;
                        r_state       <= S_RESP;
                    end else begin
                        r_idx <= r_idx + c_slot_w'(1);
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_resp_valid <= 1'b0;
                    r_req_ready  <= 1'b1;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready      = r_req_ready;
    assign resp_valid     = r_resp_valid;
    assign resultBool     = r_result_bool;
    assign isMetadata     = r_result_bool;
    assign resultMetadata = r_result_meta;
    assign resultSlot     = r_result_slot;

endmodule
`default_nettype wire

// File: tb/tb_decode_lookup.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_lookup
// Purpose  : Self-checking bench for decode_lookup against a table model.
// Revision : 1.0
// ============================================================================
module tb_decode_lookup;

    localparam int NUM_CELLS = 8;
    localparam int WIDTH     = 8;
    localparam int MAX_META  = 7;
    localparam int SW        = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             wr_en;
    logic [SW-1:0]    wr_slot;
    logic             wr_arrDef;
    logic [WIDTH-1:0] wr_handle;
    logic [WIDTH-1:0] wr_array_code;
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_code;
    logic             resp_valid;
    logic             resp_ready;
    logic             resultBool;
    logic [WIDTH-1:0] resultMetadata;
    logic [SW-1:0]    resultSlot;
    logic             isMetadata;

    always #5 clk = ~clk;

    decode_lookup #(
        .NUM_CELLS (NUM_CELLS),
        .WIDTH     (WIDTH),
        .MAX_META  (MAX_META)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .wr_en          (wr_en),
        .wr_slot        (wr_slot),
        .wr_arrDef      (wr_arrDef),
        .wr_handle      (wr_handle),
        .wr_array_code  (wr_array_code),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_code       (req_code),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resultBool     (resultBool),
        .resultMetadata (resultMetadata),
        .resultSlot     (resultSlot),
        .isMetadata     (isMetadata)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference table: what the block should currently hold.
    logic             m_def    [NUM_CELLS];
    logic [WIDTH-1:0] m_handle [NUM_CELLS];
    logic [WIDTH-1:0] m_code   [NUM_CELLS];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_clear();
        for (int i = 0; i < NUM_CELLS; i++) begin
            m_def[i]    = 1'b0;
            m_handle[i] = '0;
            m_code[i]   = '0;
        end
    endfunction

    function automatic void model_find(input logic [WIDTH-1:0] code, output logic hit,
                                       output int slot, output logic [WIDTH-1:0] meta);
        hit  = 1'b0;
        slot = 0;
        meta = '0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (!hit && m_def[i] && m_code[i] == code && int'(m_handle[i]) <= MAX_META) begin
                hit  = 1'b1;
                slot = i;
                meta = m_handle[i];
            end
        end
    endfunction

    task automatic write_cell(input int slot, input logic def, input logic [WIDTH-1:0] h,
                              input logic [WIDTH-1:0] c);
        wr_en         = 1'b1;
        wr_slot       = SW'(slot);
        wr_arrDef     = def;
        wr_handle     = h;
        wr_array_code = c;
        step();
        wr_en         = 1'b0;
        m_def[slot]    = def;
        m_handle[slot] = h;
        m_code[slot]   = c;
    endtask

    // Full lookup: request, wait for response, check result and latency, release.
    task automatic lookup(input logic [WIDTH-1:0] code, input int hold, input string tag);
        logic             eh;
        int               es;
        logic [WIDTH-1:0] em;
        int               exp_lat;
        int               lat;
        model_find(code, eh, es, em);
        exp_lat = eh ? es + 1 : NUM_CELLS;
        n_checks++;
        if (req_ready !== 1'b1) $display("FAIL %s req_ready_idle: got %b want 1", tag, req_ready);
        else n_pass++;
        req_valid = 1'b1;
        req_code  = code;
        step();
        req_valid = 1'b0;
        lat = 0;
        while (resp_valid !== 1'b1 && lat < 4 * NUM_CELLS) begin
            step();
            lat++;
        end
        n_checks++;
        if (lat !== exp_lat) $display("FAIL %s latency: got %0d want %0d", tag, lat, exp_lat);
        else n_pass++;
        repeat (hold) step();
        n_checks++;
        if (resultBool !== eh || isMetadata !== eh)
            $display("FAIL %s hit: got bool=%b meta_flag=%b want %b", tag, resultBool, isMetadata, eh);
        else n_pass++;
        n_checks++;
        if (resultMetadata !== em) $display("FAIL %s metadata: got %0d want %0d", tag, resultMetadata, em);
        else n_pass++;
        n_checks++;
        if (resultSlot !== SW'(es)) $display("FAIL %s slot: got %0d want %0d", tag, resultSlot, es);
        else n_pass++;
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        n_checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL %s release: got resp_valid=%b req_ready=%b want 0/1", tag, resp_valid, req_ready);
        else n_pass++;
    endtask

    task automatic test_reset();
        n_checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0)
            $display("FAIL reset_handshake: got req_ready=%b resp_valid=%b want 1/0", req_ready, resp_valid);
        else n_pass++;
        n_checks++;
        if (resultBool !== 1'b0 || isMetadata !== 1'b0 || resultMetadata !== '0 || resultSlot !== '0)
            $display("FAIL reset_results: got bool=%b flag=%b meta=%0d slot=%0d want all 0",
                     resultBool, isMetadata, resultMetadata, resultSlot);
        else n_pass++;
    endtask

    task automatic test_basic();
        write_cell(0, 1'b1, 8'd3, 8'h5A);
        lookup(8'h5A, 0, "hit_slot0");
        write_cell(5, 1'b1, 8'd6, 8'h22);
        write_cell(2, 1'b1, 8'd1, 8'h22);
        lookup(8'h22, 0, "dup_lowest");
        write_cell(4, 1'b1, 8'd9, 8'h40);
        lookup(8'h40, 0, "handle_over_max");
    endtask

    task automatic test_hold_response();
        int               lat;
        logic [WIDTH-1:0] q_meta;
        write_cell(3, 1'b1, 8'd7, 8'hC3);
        req_valid = 1'b1;
        req_code  = 8'hC3;
        step();
        req_valid = 1'b0;
        lat = 0;
        while (resp_valid !== 1'b1 && lat < 4 * NUM_CELLS) begin
            step();
            lat++;
        end
        n_checks++;
        if (lat !== 4) $display("FAIL hold_latency: got %0d want 4", lat);
        else n_pass++;
        q_meta = 8'd7;
        req_valid = 1'b1;
        req_code  = 8'h5A;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resultBool !== 1'b1 ||
                isMetadata !== 1'b1 || resultMetadata !== q_meta || resultSlot !== 3'd3)
                $display("FAIL hold_cycle%0d: got v=%b rdy=%b bool=%b flag=%b meta=%0d slot=%0d want 1/0/1/1/7/3",
                         i, resp_valid, req_ready, resultBool, isMetadata, resultMetadata, resultSlot);
            else n_pass++;
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        n_checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL hold_release: got resp_valid=%b req_ready=%b want 0/1", resp_valid, req_ready);
        else n_pass++;
        step();
        n_checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL hold_no_accept: got resp_valid=%b req_ready=%b want 0/1", resp_valid, req_ready);
        else n_pass++;
    endtask

    task automatic test_mid_scan_write();
        int lat;
        req_valid = 1'b1;
        req_code  = 8'h77;
        step();
        req_valid = 1'b0;
        step();
        wr_en         = 1'b1;
        wr_slot       = 3'd6;
        wr_arrDef     = 1'b1;
        wr_handle     = 8'd2;
        wr_array_code = 8'h77;
        step();
        wr_en = 1'b0;
        m_def[6] = 1'b1;
        m_handle[6] = 8'd2;
        m_code[6] = 8'h77;
        lat = 2;
        while (resp_valid !== 1'b1 && lat < 4 * NUM_CELLS) begin
            step();
            lat++;
        end
        n_checks++;
        if (lat !== 7) $display("FAIL midscan_latency: got %0d want 7", lat);
        else n_pass++;
        n_checks++;
        if (resultBool !== 1'b1 || resultSlot !== 3'd6 || resultMetadata !== 8'd2)
            $display("FAIL midscan_result: got bool=%b slot=%0d meta=%0d want 1/6/2",
                     resultBool, resultSlot, resultMetadata);
        else n_pass++;
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_scan();
        int seen;
        write_cell(7, 1'b1, 8'd5, 8'h66);
        req_valid = 1'b1;
        req_code  = 8'h66;
        step();
        req_valid = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_clear();
        n_checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resultBool !== 1'b0)
            $display("FAIL abort_state: got resp_valid=%b req_ready=%b bool=%b want 0/1/0",
                     resp_valid, req_ready, resultBool);
        else n_pass++;
        seen = 0;
        for (int i = 0; i < 2 * NUM_CELLS; i++) begin
            step();
            if (resp_valid === 1'b1) seen++;
        end
        n_checks++;
        if (seen !== 0) $display("FAIL abort_no_resp: got %0d response cycles want 0", seen);
        else n_pass++;
        lookup(8'h66, 0, "after_clear");
        lookup(8'h5A, 0, "after_clear2");
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] c;
        for (int it = 0; it < 40; it++) begin
            for (int w = 0; w < int'($urandom_range(0, 3)); w++) begin
                c = 8'h10 + 8'($urandom_range(0, 5));
                if ($urandom_range(0, 1) == 1) c = c | 8'h80;
                write_cell(int'($urandom_range(0, NUM_CELLS - 1)), $urandom_range(0, 3) != 0,
                           8'($urandom_range(0, 12)), c);
            end
            c = 8'h10 + 8'($urandom_range(0, 6));
            if ($urandom_range(0, 1) == 1) c = c | 8'h80;
            lookup(c, int'($urandom_range(0, 2)), "random");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_slot = '0; wr_arrDef = 1'b0; wr_handle = '0;
        wr_array_code = '0; req_valid = 1'b0; req_code = '0; resp_ready = 1'b0;
        model_clear();
        step();
        step();
        reset = 1'b0;
        step();
        test_reset();
        test_basic();
        test_hold_response();
        test_mid_scan_write();
        test_reset_mid_scan();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
